// File: rtl/fx_format_convert.sv
// Fixed-point re-quantiser: rescales a sample between (width, fraction) formats with
// selectable rounding and wrap/saturate, through a fixed-latency valid pipeline.
module fx_format_convert #(
  parameter int IN_W     = 13,
  parameter int IN_FRAC  = 8,
  parameter int OUT_W    = 8,
  parameter int OUT_FRAC = 4,
  parameter int SIGNED   = 1,
  parameter int RND_MODE = 0,
  parameter int OVF_MODE = 1,
  parameter int LATENCY  = 2,
  parameter int CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_clr,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_data,
  output logic             o_ovf,
  output logic             o_ovf_sticky,
  output logic [CNT_W-1:0] o_ovf_cnt
);

  localparam int D  = IN_FRAC - OUT_FRAC;
  localparam int AD = (D < 0) ? -D : D;
  localparam int DS = (D > 0) ? D : 0;
  localparam int DH = (DS > 0) ? DS - 1 : 0;
  localparam int LS = (D < 0) ? -D : 0;
  localparam int IW = IN_W + AD + 1;
  localparam int CW = (IW > OUT_W + 1) ? IW : OUT_W + 1;
  localparam int NL = (LATENCY == 1) ? 1 : LATENCY - 1;

  localparam logic [IW-1:0] ONE_I = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0] FMASK = (ONE_I << DS) - ONE_I;
  localparam logic [IW-1:0] HALF  = (DS > 0) ? (ONE_I << DH) : {IW{1'b0}};
  localparam logic signed [CW-1:0] OMAX = (SIGNED != 0) ? $signed((ONE_C << (OUT_W - 1)) - ONE_C)
                                                        : $signed((ONE_C << OUT_W) - ONE_C);
  localparam logic signed [CW-1:0] OMIN = (SIGNED != 0) ? $signed(-(ONE_C << (OUT_W - 1)))
                                                        : $signed({CW{1'b0}});

  // Range check and wrap/clamp of a rounded value; result is {overflow, data}.
  function automatic logic [OUT_W:0] f_limit(input logic signed [CW-1:0] q);
    logic             ov;
    logic [OUT_W-1:0] v;
    ov = (q > OMAX) || (q < OMIN);
    if (ov && (OVF_MODE == 1)) begin
      v = q[CW-1] ? OMIN[OUT_W-1:0] : OMAX[OUT_W-1:0];
    end else begin
      v = q[OUT_W-1:0];
    end
    return {ov, v};
  endfunction

  logic signed [IN_W-1:0] din_s;
  logic signed [IW-1:0]   ext_s;
  logic signed [IW-1:0]   flr_s;
  logic signed [IW-1:0]   quant_s;
  logic [IW-1:0]          frac_s;
  logic                   half_s;
  logic                   rnd_inc_s;
  logic signed [CW-1:0]   quant_d;

  assign din_s = i_data;

  // Extend, align the binary point and round the dropped LSBs.
  always_comb begin
    if (SIGNED != 0) begin
      ext_s = IW'(din_s);
    end else begin
      ext_s = $signed(IW'(i_data));
    end
    flr_s  = ext_s >>> DS;
    frac_s = $unsigned(ext_s) & FMASK;
    half_s = (frac_s & HALF) != {IW{1'b0}};
    case (RND_MODE)
      1:       rnd_inc_s = half_s;
      2:       rnd_inc_s = half_s && ((frac_s != HALF) || flr_s[0]);
      default: rnd_inc_s = 1'b0;
    endcase
    quant_s = (flr_s <<< LS) + $signed({{(IW-1){1'b0}}, rnd_inc_s});
    quant_d = CW'(quant_s);
  end

  logic signed [CW-1:0] lim_in_s;
  logic                 lim_vld_s;
  logic [OUT_W:0]       lim_d;

  generate
    if (LATENCY == 1) begin : g_single
      assign lim_in_s  = quant_d;
      assign lim_vld_s = i_valid;
    end else begin : g_split
      logic signed [CW-1:0] q1_q;
      logic                 v1_q;

      // Quantise stage: holds the rounded value of the last accepted sample.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          q1_q <= {CW{1'b0}};
          v1_q <= 1'b0;
        end else begin
          v1_q <= i_valid;
          if (i_valid) begin
            q1_q <= quant_d;
          end
        end
      end

      assign lim_in_s  = q1_q;
      assign lim_vld_s = v1_q;
    end
  endgenerate

  assign lim_d = f_limit(lim_in_s);

  logic [OUT_W:0]  pipe_q [NL];
  logic [NL-1:0]   pvld_q;

  // Overflow stage followed by pure delay; data only moves with its valid bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < NL; k++) begin
        pipe_q[k] <= {(OUT_W+1){1'b0}};
      end
      pvld_q <= {NL{1'b0}};
    end else begin
      pvld_q[0] <= lim_vld_s;
      if (lim_vld_s) begin
        pipe_q[0] <= lim_d;
      end
      for (int k = 1; k < NL; k++) begin
        pvld_q[k] <= pvld_q[k-1];
        if (pvld_q[k-1]) begin
          pipe_q[k] <= pipe_q[k-1];
        end
      end
    end
  end

  assign o_valid = pvld_q[NL-1];
  assign o_ovf   = pipe_q[NL-1][OUT_W];
  assign o_data  = pipe_q[NL-1][OUT_W-1:0];

  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             evt_s;

  assign evt_s = o_valid & o_ovf;

  // A presented overflow always wins over a clear so the event is never lost.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (evt_s) begin
      sticky_d = 1'b1;
      if (i_clr) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (i_clr) begin
      sticky_d = 1'b0;
      cnt_d    = {CNT_W{1'b0}};
    end else begin
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
    end
  end

  // Overflow statistics registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sticky_q <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_ovf_sticky = sticky_q;
  assign o_ovf_cnt    = cnt_q;

endmodule

// File: tb/tb_fx_format_convert.sv
// Directed bench: several converter configurations driven from one shared stimulus.
module tb_fx_format_convert;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic [12:0] din = 13'h0;
  logic        clr = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  logic r0_v, r0_o, r0_s; logic [7:0] r0_d; logic [15:0] r0_c;
  logic r1_v, r1_o, r1_s; logic [7:0] r1_d; logic [15:0] r1_c;
  logic r2_v, r2_o, r2_s; logic [7:0] r2_d; logic [15:0] r2_c;
  logic wr_v, wr_o, wr_s; logic [7:0] wr_d; logic [15:0] wr_c;
  logic l1_v, l1_o, l1_s; logic [7:0] l1_d; logic [15:0] l1_c;
  logic l3_v, l3_o, l3_s; logic [7:0] l3_d; logic [15:0] l3_c;
  logic ct_v, ct_o, ct_s; logic [7:0] ct_d; logic [3:0]  ct_c;
  logic wd_v, wd_o, wd_s; logic [12:0] wd_d; logic [15:0] wd_c;

  fx_format_convert #(.RND_MODE(0)) u_r0 (.i_clk(clk), .i_rst(rst), .i_valid(vld), .i_data(din), .i_clr(clr),
    .o_valid(r0_v), .o_data(r0_d), .o_ovf(r0_o), .o_ovf_sticky(r0_s), .o_ovf_cnt(r0_c));
  fx_format_convert #(.RND_MODE(1)) u_r1 (.i_clk(clk), .i_rst(rst), .i_valid(vld), .i_data(din), .i_clr(clr),
    .o_valid(r1_v), .o_data(r1_d), .o_ovf(r1_o), .o_ovf_sticky(r1_s), .o_ovf_cnt(r1_c));
  fx_format_convert #(.RND_MODE(2)) u_r2 (.i_clk(clk), .i_rst(rst), .i_valid(vld), .i_data(din), .i_clr(clr),
    .o_valid(r2_v), .o_data(r2_d), .o_ovf(r2_o), .o_ovf_sticky(r2_s), .o_ovf_cnt(r2_c));
  fx_format_convert #(.RND_MODE(0), .OVF_MODE(0)) u_wr (.i_clk(clk), .i_rst(rst), .i_valid(vld), .i_data(din), .i_clr(clr),
    .o_valid(wr_v), .o_data(wr_d), .o_ovf(wr_o), .o_ovf_sticky(wr_s), .o_ovf_cnt(wr_c));
  fx_format_convert #(.LATENCY(1)) u_l1 (.i_clk(clk), .i_rst(rst), .i_valid(vld), .i_data(din), .i_clr(clr),
    .o_valid(l1_v), .o_data(l1_d), .o_ovf(l1_o), .o_ovf_sticky(l1_s), .o_ovf_cnt(l1_c));
  fx_format_convert #(.LATENCY(3)) u_l3 (.i_clk(clk), .i_rst(rst), .i_valid(vld), .i_data(din), .i_clr(clr),
    .o_valid(l3_v), .o_data(l3_d), .o_ovf(l3_o), .o_ovf_sticky(l3_s), .o_ovf_cnt(l3_c));
  fx_format_convert #(.CNT_W(4)) u_ct (.i_clk(clk), .i_rst(rst), .i_valid(vld), .i_data(din), .i_clr(clr),
    .o_valid(ct_v), .o_data(ct_d), .o_ovf(ct_o), .o_ovf_sticky(ct_s), .o_ovf_cnt(ct_c));
  fx_format_convert #(.IN_W(8), .IN_FRAC(4), .OUT_W(13), .OUT_FRAC(8), .SIGNED(0)) u_wd (.i_clk(clk), .i_rst(rst),
    .i_valid(vld), .i_data(din[7:0]), .i_clr(clr),
    .o_valid(wd_v), .o_data(wd_d), .o_ovf(wd_o), .o_ovf_sticky(wd_s), .o_ovf_cnt(wd_c));

  typedef struct {
    logic [12:0] din;
    logic [7:0]  e0, e1, e2, ew;
    logic        v0, v1, v2, vw;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1; vld = 1'b0; clr = 1'b0;
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    logic [7:0] ldat [3];
    logic [7:0] hold;
    int         k;
    logic       ev;

    vt[0]  = '{13'h0018, 8'h01, 8'h02, 8'h02, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{13'h0028, 8'h02, 8'h03, 8'h02, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{13'h1FE8, 8'hFE, 8'hFF, 8'hFE, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{13'h0FFF, 8'h7F, 8'h7F, 8'h7F, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[4]  = '{13'h1000, 8'h80, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[5]  = '{13'h07F8, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[6]  = '{13'h07F0, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{13'h0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{13'h1800, 8'h80, 8'h80, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{13'h17F8, 8'h80, 8'h80, 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[10] = '{13'h0038, 8'h03, 8'h04, 8'h04, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{13'h0029, 8'h02, 8'h03, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state.
    @(negedge clk); @(negedge clk);
    chk("rst_valid", {31'd0, r0_v}, 32'd0);
    chk("rst_data", {24'd0, r0_d}, 32'd0);
    chk("rst_ovf", {31'd0, r0_o}, 32'd0);
    chk("rst_sticky", {31'd0, r0_s}, 32'd0);
    chk("rst_cnt", {16'd0, r0_c}, 32'd0);
    chk("rst_l3_valid", {31'd0, l3_v}, 32'd0);
    rst = 1'b0;

    // Rounding / overflow vectors, one sample at a time.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); vld = 1'b1; din = vt[i].din;
      @(posedge clk); #1;
      chk("l1_valid", {31'd0, l1_v}, 32'd1);
      chk("l1_data", {24'd0, l1_d}, {24'd0, vt[i].e0});
      chk("l1_ovf", {31'd0, l1_o}, {31'd0, vt[i].v0});
      chk("r0_early_valid", {31'd0, r0_v}, 32'd0);
      @(negedge clk); vld = 1'b0; din = 13'h0;
      @(posedge clk); #1;
      chk("r0_valid", {31'd0, r0_v}, 32'd1);
      chk("r0_data", {24'd0, r0_d}, {24'd0, vt[i].e0});
      chk("r0_ovf", {31'd0, r0_o}, {31'd0, vt[i].v0});
      chk("r1_data", {24'd0, r1_d}, {24'd0, vt[i].e1});
      chk("r1_ovf", {31'd0, r1_o}, {31'd0, vt[i].v1});
      chk("r2_data", {24'd0, r2_d}, {24'd0, vt[i].e2});
      chk("r2_ovf", {31'd0, r2_o}, {31'd0, vt[i].v2});
      chk("wr_data", {24'd0, wr_d}, {24'd0, vt[i].ew});
      chk("wr_ovf", {31'd0, wr_o}, {31'd0, vt[i].vw});
      @(posedge clk); #1;
      chk("r0_hold_valid", {31'd0, r0_v}, 32'd0);
      chk("r0_hold_data", {24'd0, r0_d}, {24'd0, vt[i].e0});
    end

    // Counter saturation, clear, and clear coincident with an event.
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      vld = 1'b1; din = 13'h0FFF;
      @(negedge clk);
    end
    vld = 1'b0;
    repeat (4) @(negedge clk);
    chk("cnt4_sat", {28'd0, ct_c}, 32'd15);
    chk("cnt4_sticky", {31'd0, ct_s}, 32'd1);
    chk("cnt16_count", {16'd0, r0_c}, 32'd20);
    clr = 1'b1;
    @(posedge clk); #1;
    chk("clr_cnt", {28'd0, ct_c}, 32'd0);
    chk("clr_sticky", {31'd0, ct_s}, 32'd0);
    @(negedge clk); clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vld = 1'b1; din = 13'h0FFF;
      @(negedge clk);
    end
    vld = 1'b0;
    repeat (4) @(negedge clk);
    chk("cnt_three", {28'd0, ct_c}, 32'd3);
    vld = 1'b1; din = 13'h0FFF;
    @(posedge clk);
    @(negedge clk); vld = 1'b0;
    @(posedge clk); #1;
    chk("evt_valid", {31'd0, ct_v}, 32'd1);
    chk("evt_ovf", {31'd0, ct_o}, 32'd1);
    chk("evt_cnt_before", {28'd0, ct_c}, 32'd3);
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1;
    chk("coinc_cnt", {28'd0, ct_c}, 32'd1);
    chk("coinc_sticky", {31'd0, ct_s}, 32'd1);
    @(negedge clk); clr = 1'b0;

    // LATENCY=3: valids in cycles 0, 1, 5 appear in cycles 3, 4, 8; data holds between.
    pulse_reset();
    ldat[0] = 8'h01; ldat[1] = 8'h02; ldat[2] = 8'hFE;
    hold = 8'h00; k = 0;
    for (int c = 0; c < 11; c++) begin
      vld = (c == 0) || (c == 1) || (c == 5);
      din = (c == 0) ? 13'h0018 : (c == 1) ? 13'h0028 : (c == 5) ? 13'h1FE8 : 13'h0000;
      @(posedge clk); #1;
      ev = ((c + 1) == 3) || ((c + 1) == 4) || ((c + 1) == 8);
      if (ev) begin
        hold = ldat[k];
        k++;
      end
      chk("l3_valid", {31'd0, l3_v}, {31'd0, ev});
      chk("l3_data", {24'd0, l3_d}, {24'd0, hold});
      @(negedge clk);
    end

    // Reset in cycle 2 discards the two in-flight samples; cycle-4 sample lands in cycle 7.
    vld = 1'b0;
    for (int c = 0; c < 9; c++) begin
      rst = (c == 2);
      vld = (c == 0) || (c == 1) || (c == 4);
      din = (c == 4) ? 13'h0028 : 13'h0018;
      @(posedge clk); #1;
      chk("rst_mid_valid", {31'd0, l3_v}, {31'd0, ((c + 1) == 7)});
      if ((c + 1) == 7) begin
        chk("rst_mid_data", {24'd0, l3_d}, 32'h02);
      end
      @(negedge clk);
    end
    rst = 1'b0; vld = 1'b0;

    // Widening 8.4 unsigned -> 13.8: all 256 inputs, back to back.
    for (int i = 0; i < 258; i++) begin
      if (i >= 2) begin
        chk("wid_valid", {31'd0, wd_v}, 32'd1);
        chk("wid_data", {19'd0, wd_d}, (i - 2) * 16);
        chk("wid_ovf", {31'd0, wd_o}, 32'd0);
      end
      vld = (i < 256);
      din = 13'(i & 255);
      @(negedge clk);
    end
    vld = 1'b0;
    chk("wid_sticky", {31'd0, wd_s}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
